// File: rtl/proc_pkg.sv
// Shared definitions for the memory-stage access sequencer.
// Holds the sequencer state encoding, the default scalar/vector widths and
// the derived per-vector beat count and per-beat byte step.
package proc_pkg;

  localparam int V_W    = 128;          // vector width in bits
  localparam int N_W    = 32;           // scalar / memory data width in bits
  localparam int VBEATS = V_W / N_W;    // memory beats per vector access
  localparam int VSTEP  = N_W / 8;      // byte-address increment per beat

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mseq_state_t;

  // Beat counter width; a single-beat configuration still needs one bit.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_reg.sv
// Plain enabled register with asynchronous active-low clear.
// Ports:
//   clk_i    - clock, rising edge
//   rst_n_i  - asynchronous active-low reset (clears q_o)
//   en_i     - load d_i on the next rising edge
//   d_i      - data in
//   q_o      - registered data out
module mseq_register #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_seq_ctrl_vlane_buf.sv
// V-bit vector load buffer, written one N-bit lane per memory beat.
// next_o shows the buffer contents including this cycle's lane write, so the
// owner can capture a complete vector on the same edge as the final beat.
// Ports:
//   clk_i    - clock, rising edge
//   rst_n_i  - asynchronous active-low reset (clears all lanes)
//   we_i     - write lane lane_i with wdata_i this cycle
//   lane_i   - lane index (lane 0 = bits [N-1:0])
//   wdata_i  - lane write data
//   next_o   - buffer value after this cycle's write
module vlane_buf
  import proc_pkg::*;
#(
  parameter int V  = V_W,
  parameter int N  = N_W,
  parameter int BW = beat_width(V / N)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [BW-1:0] lane_i,
  input  logic [N-1:0]  wdata_i,
  output logic [V-1:0]  next_o
);

  logic [V-1:0] buf_q;
  logic [V-1:0] buf_d;

  always_comb begin
    buf_d = buf_q;
    if (we_i) begin
      buf_d[int'(lane_i) * N +: N] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign next_o = buf_d;

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory-stage access sequencer. Sits between the execute/memory pipeline
// register outputs and a single-port N-bit data memory. Scalar accesses take
// one memory beat; V-bit vector accesses are split into V/N beats at
// ascending addresses (beat 0 <-> bits [N-1:0]) and loads are reassembled.
// The pipeline is held with stall until the access retires.
//
// Handshake: in ACCESS the strobe (mem_we or mem_re), mem_addr and mem_wdata
// are held stable until the memory returns mem_ready=1 in the same cycle; a
// beat completes on every clock edge where the strobe and mem_ready are both
// high. mem_we and mem_re are never high together.
//
// Ports:
//   clk, rst               - clock; asynchronous active-low reset
//   req_valid/req_wr/req_vec - access request, store/load, vector/scalar
//   address                - byte base address (aligned down to N/8 bytes)
//   wdata_s / wdata_v      - scalar / vector store data
//   mem_ready / mem_rdata  - memory completion and read data
//   mem_addr/mem_wdata/mem_we/mem_re - memory request
//   rdata_s / rdata_v      - last scalar / vector load result (held)
//   rdata_valid            - one-cycle pulse when a load retires
//   stall                  - freeze upstream pipeline registers
//   dbg_state              - current sequencer state
module mem_seq_ctrl
  import proc_pkg::*;
#(
  parameter int V = V_W,
  parameter int N = N_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_wr,
  input  logic         req_vec,
  input  logic [N-1:0] address,
  input  logic [N-1:0] wdata_s,
  input  logic [V-1:0] wdata_v,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  output logic         mem_re,
  output logic [N-1:0] rdata_s,
  output logic [V-1:0] rdata_v,
  output logic         rdata_valid,
  output logic         stall,
  output logic [1:0]   dbg_state
);

  localparam int BEATS = V / N;
  localparam int STEP  = N / 8;
  localparam int BW    = beat_width(BEATS);
  localparam logic [N-1:0] ALIGN_MASK = ~(N'(STEP) - N'(1));
  localparam logic [BW-1:0] LAST_VEC  = BW'(BEATS - 1);

  mseq_state_t   state_q;
  logic [BW-1:0] beat_q;
  logic          wr_q;
  logic          vec_q;
  logic [N-1:0]  wdata_s_q;
  logic [V-1:0]  wdata_v_q;
  logic [N-1:0]  rdata_s_q;
  logic [V-1:0]  rdata_v_q;
  logic          rdata_valid_q;

  logic [N-1:0]  base_q;
  logic [V-1:0]  vbuf_next;
  logic          accept;
  logic          beat_done;
  logic          last_beat;
  logic          lane_we;

  assign accept    = (state_q == IDLE) && req_valid;
  assign beat_done = (state_q == ACCESS) && mem_ready;
  assign last_beat = vec_q ? (beat_q == LAST_VEC) : 1'b1;
  assign lane_we   = beat_done && !wr_q && vec_q;

  // Base address is latched once on acceptance, aligned to a beat boundary.
  mseq_register #(.W(N)) u_base_reg (
    .clk_i   (clk),
    .rst_n_i (rst),
    .en_i    (accept),
    .d_i     (address & ALIGN_MASK),
    .q_o     (base_q)
  );

  vlane_buf #(.V(V), .N(N), .BW(BW)) u_vlane_buf (
    .clk_i   (clk),
    .rst_n_i (rst),
    .we_i    (lane_we),
    .lane_i  (beat_q),
    .wdata_i (mem_rdata),
    .next_o  (vbuf_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wr_q          <= 1'b0;
      vec_q         <= 1'b0;
      wdata_s_q     <= '0;
      wdata_v_q     <= '0;
      rdata_s_q     <= '0;
      rdata_v_q     <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdata_valid_q <= 1'b0;
          if (req_valid) begin
            wr_q      <= req_wr;
            vec_q     <= req_vec;
            wdata_s_q <= wdata_s;
            wdata_v_q <= wdata_v;
            beat_q    <= '0;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= DONE;
              if (!wr_q) begin
                // Result registers change only when a load retires, so they
                // hold the previous result through any later access.
                rdata_valid_q <= 1'b1;
                if (vec_q) begin
                  rdata_v_q <= vbuf_next;
                end else begin
                  rdata_s_q <= mem_rdata;
                end
              end
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        DONE: begin
          // The request still visible here is the one retiring now.
          rdata_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          rdata_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        // The request cycle itself is stalled; gated so reset forces it low.
        stall = req_valid && rst;
      end
      ACCESS: begin
        stall    = 1'b1;
        mem_addr = base_q + N'(beat_q) * N'(STEP);
        mem_we   = wr_q;
        mem_re   = !wr_q;
        if (wr_q) begin
          mem_wdata = vec_q ? wdata_v_q[int'(beat_q) * N +: N] : wdata_s_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign rdata_s     = rdata_s_q;
  assign rdata_v     = rdata_v_q;
  assign rdata_valid = rdata_valid_q;
  assign dbg_state   = state_q;

endmodule
